// File: rtl/memory_responder_pkg.sv
// Shared widths, FSM encodings and request-op type for the memory responder.
// Elaboration-time helpers used to validate the responder parameters live here too.
package memory_responder_pkg;

  localparam int DATA_INDEX_LIMIT    = 31;
  localparam int ADDRESS_INDEX_LIMIT = 25;
  localparam int DATA_WIDTH          = DATA_INDEX_LIMIT + 1;
  localparam int ADDRESS_WIDTH       = ADDRESS_INDEX_LIMIT + 1;
  localparam int CNT_WIDTH           = 4;

  typedef enum logic [1:0] {
    MEMR_IDLE = 2'b00,
    MEMR_BUSY = 2'b01,
    MEMR_ACK  = 2'b10
  } memr_state_t;

  typedef struct packed {
    logic rd;
    logic wr;
  } req_op_t;

  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/memory_responder_if.sv
// Request/response bus between the data path (master) and the memory responder (slave).
interface memory_responder_if;
  import memory_responder_pkg::*;

  logic [ADDRESS_INDEX_LIMIT:0] ADDR;
  logic [DATA_INDEX_LIMIT:0]    DATA_IN;
  logic                         READ;
  logic                         WRITE;
  logic [DATA_INDEX_LIMIT:0]    DATA_OUT;
  logic                         READY;
  logic                         ERR;

  modport master (
    output ADDR, DATA_IN, READ, WRITE,
    input  DATA_OUT, READY, ERR
  );

  modport slave (
    input  ADDR, DATA_IN, READ, WRITE,
    output DATA_OUT, READY, ERR
  );
endinterface

// File: rtl/memory_responder_mem_word_array.sv
// Single-port synchronous word array; write and registered read share one index.
module mem_word_array
  import memory_responder_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic                         CLK,
  input  logic                         WE,
  input  logic [$clog2(DEPTH)-1:0]     IDX,
  input  logic [DATA_INDEX_LIMIT:0]    WD,
  output logic [DATA_INDEX_LIMIT:0]    RD
);

  logic [DATA_INDEX_LIMIT:0] r_mem [DEPTH];
  logic [DATA_INDEX_LIMIT:0] r_rd;

  // NOTE: the storage array has no reset so it maps onto RAM macros; contents survive RST.
  always_ff @(posedge CLK) begin
    if (WE) begin
      r_mem[IDX] <= WD;
    end
    r_rd <= r_mem[IDX];
  end

  assign RD = r_rd;

endmodule

// File: rtl/memory_responder.sv
// Memory-side responder: captures a READ/WRITE request, waits LATENCY cycles, performs
// the access on the word array and completes with a four-phase READY/ERR handshake.
module memory_responder
  import memory_responder_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic               CLK,
  input  logic               RST,
  memory_responder_if.slave  bus
);

  localparam int                    IDX_W    = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0]  LAT_LOAD = CNT_WIDTH'(LATENCY - 1);
  localparam logic [31:0]           DEPTH_U  = 32'(DEPTH);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("memory_responder: LATENCY must be in 1..15");
  end
  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("memory_responder: DEPTH must be a power of two");
  end

  memr_state_t                  r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0]         r_cnt, w_cnt_nxt;
  logic [ADDRESS_INDEX_LIMIT:0] r_addr, w_addr_nxt;
  logic [DATA_INDEX_LIMIT:0]    r_wdata, w_wdata_nxt;
  req_op_t                      r_op, w_op_nxt;
  logic                         r_err, w_err_nxt;
  logic [DATA_INDEX_LIMIT:0]    r_data_out, w_data_out_nxt;
  logic                         r_sel_array, w_sel_array_nxt;

  logic                         w_we;
  logic                         w_in_range;
  logic                         w_single_op;
  logic [IDX_W-1:0]             w_idx;
  logic [DATA_INDEX_LIMIT:0]    w_rd;

  // Range check on the full address before the truncated index is trusted.
  assign w_in_range  = {{(32 - ADDRESS_WIDTH){1'b0}}, r_addr} < DEPTH_U;
  assign w_single_op = r_op.rd ^ r_op.wr;
  assign w_idx       = r_addr[IDX_W-1:0];

  mem_word_array #(.DEPTH(DEPTH)) u_array (
    .CLK (CLK),
    .WE  (w_we),
    .IDX (w_idx),
    .WD  (r_wdata),
    .RD  (w_rd)
  );

  // NOTE: every signal written here gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_addr_nxt      = r_addr;
    w_wdata_nxt     = r_wdata;
    w_op_nxt        = r_op;
    w_err_nxt       = r_err;
    w_data_out_nxt  = r_data_out;
    w_sel_array_nxt = r_sel_array;
    w_we            = 1'b0;

    unique case (r_state)
      MEMR_IDLE: begin
        if (bus.READ || bus.WRITE) begin
          w_addr_nxt  = bus.ADDR;
          w_wdata_nxt = bus.DATA_IN;
          w_op_nxt    = '{rd: bus.READ, wr: bus.WRITE};
          w_cnt_nxt   = LAT_LOAD;
          w_state_nxt = MEMR_BUSY;
        end
      end
      MEMR_BUSY: begin
        if (r_cnt == '0) begin
          w_state_nxt = MEMR_ACK;
          if (w_in_range && w_single_op) begin
            w_err_nxt = 1'b0;
            if (r_op.rd) begin
              w_sel_array_nxt = 1'b1;
            end else begin
              w_we = 1'b1;
            end
          end else begin
            w_err_nxt = 1'b1;
            if (w_single_op && r_op.rd) begin
              w_data_out_nxt = '0;
            end
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      MEMR_ACK: begin
        if (!bus.READ && !bus.WRITE) begin
          w_state_nxt = MEMR_IDLE;
          w_err_nxt   = 1'b0;
          // The array output follows its index later, so freeze the read word on release.
          if (r_sel_array) begin
            w_data_out_nxt  = w_rd;
            w_sel_array_nxt = 1'b0;
          end
        end
      end
      default: begin
        w_state_nxt = MEMR_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= MEMR_IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_op        <= '0;
      r_err       <= 1'b0;
      r_data_out  <= '0;
      r_sel_array <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_op        <= w_op_nxt;
      r_err       <= w_err_nxt;
      r_data_out  <= w_data_out_nxt;
      r_sel_array <= w_sel_array_nxt;
    end
  end

  assign bus.READY    = (r_state == MEMR_ACK);
  assign bus.ERR      = r_err;
  assign bus.DATA_OUT = r_sel_array ? w_rd : r_data_out;

endmodule
